// File: rtl/uart_rx_edge_sampler_pkg.sv
// Shared constants and helpers for the UART receive path.
// Frame shape, minimum oversampling ratio and the 3-sample majority vote.
package uart_rx_pkg;

  localparam int PRESCALE_MIN   = 4;
  localparam int DEF_PRESCALE_W = 5;
  localparam int DEF_BIT_CNT_W  = 4;

  localparam int START_BITS  = 1;
  localparam int DATA_BITS   = 8;
  localparam int PARITY_BITS = 1;
  localparam int STOP_BITS   = 1;
  localparam int FRAME_BITS_NO_PARITY = START_BITS + DATA_BITS + STOP_BITS;
  localparam int FRAME_BITS_PARITY    = FRAME_BITS_NO_PARITY + PARITY_BITS;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_edge_sampler_if.sv
// Sampler <-> RX control FSM bundle; slave is the sampler, master the FSM side.
// No handshake: counters and the sample_done pulse are consumed combinationally.
interface uart_rx_edge_sampler_if #(
  parameter int PRESCALE_W = uart_rx_pkg::DEF_PRESCALE_W,
  parameter int BIT_CNT_W  = uart_rx_pkg::DEF_BIT_CNT_W
);
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] PRESCALE;
  logic                  COUNTER_EN;
  logic                  SAMPLE_EN;
  logic [PRESCALE_W-1:0] EDGE_COUNT;
  logic [BIT_CNT_W-1:0]  BIT_COUNT;
  logic                  SAMPLED_BIT;
  logic                  sample_done;

  modport master (
    output RX_IN, PRESCALE, COUNTER_EN, SAMPLE_EN,
    input  EDGE_COUNT, BIT_COUNT, SAMPLED_BIT, sample_done
  );

  modport slave (
    input  RX_IN, PRESCALE, COUNTER_EN, SAMPLE_EN,
    output EDGE_COUNT, BIT_COUNT, SAMPLED_BIT, sample_done
  );
endinterface

// File: rtl/uart_rx_edge_sampler_sync.sv
// Bit synchronizer for RX_IN, STAGES flops deep, resetting to the idle-high level.
// Latency STAGES clocks; STAGES=0 is a wire. No backpressure.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);
  generate
    if (STAGES == 0) begin : g_bypass
      assign q = d;
    end else begin : g_sync
      logic [STAGES-1:0] ff;
      always_ff @(posedge CLK) begin
        if (RST) ff <= '1;
        else     ff <= STAGES'({ff, d});
      end
      assign q = ff[STAGES-1];
    end
  endgenerate
endmodule

// File: rtl/uart_rx_edge_sampler.sv
// Oversampling edge/bit counters plus 3-sample majority voter for the UART RX FSM.
// RX_IN->vote SYNC_STAGES clocks, vote->SAMPLED_BIT/sample_done 1 clock; no backpressure.
module uart_rx_edge_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int PRESCALE_W  = uart_rx_pkg::DEF_PRESCALE_W,
  parameter int BIT_CNT_W   = uart_rx_pkg::DEF_BIT_CNT_W
) (
  input logic                   CLK,
  input logic                   RST,
  uart_rx_edge_sampler_if.slave bus
);
  import uart_rx_pkg::*;

  logic                  rx_s;
  logic [PRESCALE_W-1:0] p_eff;
  logic [PRESCALE_W-1:0] mid;
  logic                  wrap;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  s0;
  logic                  s1;
  logic                  sampled;
  logic                  done;

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (bus.RX_IN),
    .q   (rx_s)
  );

  always_comb begin
    p_eff = bus.PRESCALE;
    if (bus.PRESCALE < PRESCALE_W'(PRESCALE_MIN)) p_eff = PRESCALE_W'(PRESCALE_MIN);
    mid  = p_eff >> 1;
    // >= so a mid-bit PRESCALE decrease wraps immediately instead of running away
    wrap = (edge_cnt >= p_eff - PRESCALE_W'(1));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
      s0       <= 1'b1;
      s1       <= 1'b1;
      sampled  <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!bus.COUNTER_EN) begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
      end else if (wrap) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
      end else begin
        edge_cnt <= edge_cnt + PRESCALE_W'(1);
      end

      if (bus.SAMPLE_EN && bus.COUNTER_EN) begin
        if (edge_cnt == mid - PRESCALE_W'(1)) s0 <= rx_s;
        if (edge_cnt == mid)                  s1 <= rx_s;
      end
      // Vote ignores COUNTER_EN so a disable landing in the M+1 cycle still finishes the bit
      if (bus.SAMPLE_EN && (edge_cnt == mid + PRESCALE_W'(1))) begin
        sampled <= maj3(s0, s1, rx_s);
        done    <= 1'b1;
      end
    end
  end

  assign bus.EDGE_COUNT  = edge_cnt;
  assign bus.BIT_COUNT   = bit_cnt;
  assign bus.SAMPLED_BIT = sampled;
  assign bus.sample_done = done;
endmodule

// File: tb/tb_uart_rx_edge_sampler.sv
// Randomized bench for uart_rx_edge_sampler: per-bit majority model feeds a scoreboard
// queue that an independent monitor drains on every sample_done pulse.
module tb_uart_rx_edge_sampler;
  localparam int S = 2;

  logic CLK = 1'b0;
  logic RST;

  uart_rx_edge_sampler_if #(.PRESCALE_W(5), .BIT_CNT_W(4)) bus ();

  uart_rx_edge_sampler #(.SYNC_STAGES(S), .PRESCALE_W(5), .BIT_CNT_W(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic bitv;
    int   bcnt;
    int   ecnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every pulse must match the oldest expected bit
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (bus.sample_done === 1'b1) begin
        pulses++;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sampled_bit", int'(bus.SAMPLED_BIT), int'(e.bitv));
          check("pulse_bit_count", int'(bus.BIT_COUNT), e.bcnt);
          check("pulse_edge_count", int'(bus.EDGE_COUNT), e.ecnt);
        end
      end
    end
  end

  // line[c] is the synchronized level seen in counter cycle c (bit k spans k*pe .. k*pe+pe-1).
  // gmode: 0 clean, 1 flip mid sample, 2 flip mid and mid+1 samples, 3 random noise.
  task automatic run_frame(input int pre, input int nb, input logic [31:0] bits, input int gmode);
    int pe, m, n, p0, max_e;
    bit line[];
    pe = (pre < 4) ? 4 : pre;
    m  = pe / 2;
    n  = nb * pe;
    line = new[n];
    for (int k = 0; k < nb; k++)
      for (int j = 0; j < pe; j++) line[k*pe + j] = bits[k];
    for (int k = 0; k < nb; k++) begin
      if (gmode == 1 || gmode == 2) line[k*pe + m] = ~bits[k];
      if (gmode == 2) line[k*pe + m + 1] = ~bits[k];
    end
    if (gmode == 3)
      for (int i = 0; i < n; i++)
        if ($urandom_range(0, 5) == 0) line[i] = ~line[i];
    for (int k = 0; k < nb; k++) begin
      exp_t e;
      int ones;
      ones   = int'(line[k*pe + m - 1]) + int'(line[k*pe + m]) + int'(line[k*pe + m + 1]);
      e.bitv = (ones >= 2);
      e.bcnt = (k + ((m + 2 >= pe) ? 1 : 0)) % 16;
      e.ecnt = (m + 2) % pe;
      exp_q.push_back(e);
    end
    p0    = pulses;
    max_e = 0;
    bus.PRESCALE  = 5'(pre);
    bus.SAMPLE_EN = 1'b1;
    for (int d = 0; d <= n + S; d++) begin
      @(negedge CLK);
      if (int'(bus.EDGE_COUNT) > max_e) max_e = int'(bus.EDGE_COUNT);
      bus.RX_IN      = (d < n) ? line[d] : 1'b1;
      bus.COUNTER_EN = (d >= S);
      if (d == n + S) begin
        check("frame_end_edge_count", int'(bus.EDGE_COUNT), 0);
        check("frame_end_bit_count", int'(bus.BIT_COUNT), nb % 16);
      end
    end
    @(negedge CLK);
    bus.COUNTER_EN = 1'b0;
    bus.SAMPLE_EN  = 1'b0;
    bus.RX_IN      = 1'b1;
    check("frame_pulse_count", pulses - p0, nb);
    check("frame_edge_below_p", int'(max_e < pe), 1);
  endtask

  initial begin
    bit found;
    logic held;

    RST = 1'b1;
    bus.RX_IN = 1'b1;
    bus.PRESCALE = 5'd8;
    bus.COUNTER_EN = 1'b0;
    bus.SAMPLE_EN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_edge_count", int'(bus.EDGE_COUNT), 0);
    check("reset_bit_count", int'(bus.BIT_COUNT), 0);
    check("reset_sample_done", int'(bus.sample_done), 0);
    check("reset_sampled_bit", int'(bus.SAMPLED_BIT), 1);
    @(negedge CLK);
    RST = 1'b0;
    repeat (S + 1) @(negedge CLK);

    run_frame(8, 1, 32'h0, 0);
    run_frame(16, 1, 32'h1, 1);
    run_frame(16, 1, 32'h1, 2);
    run_frame(16, 11, (32'h1 << 10) | (32'h1 << 9) | (32'hA5 << 1), 0);
    run_frame(2, 6, $urandom, 0);
    run_frame(3, 6, $urandom, 3);
    run_frame(4, 18, $urandom, 3);
    repeat (8) run_frame(int'($urandom_range(0, 31)), int'($urandom_range(1, 12)), $urandom, 3);

    // PRESCALE 16 -> 8 while EDGE_COUNT is 12
    @(negedge CLK);
    bus.PRESCALE = 5'd16;
    bus.COUNTER_EN = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge CLK);
      #1;
      if (bus.EDGE_COUNT == 5'd12) found = 1'b1;
    end
    check("reached_edge_12", int'(found), 1);
    @(negedge CLK);
    bus.PRESCALE = 5'd8;
    @(posedge CLK);
    #1;
    check("shrink_edge_wrap", int'(bus.EDGE_COUNT), 0);
    check("shrink_bit_inc", int'(bus.BIT_COUNT), 1);
    @(negedge CLK);
    bus.COUNTER_EN = 1'b0;
    @(negedge CLK);

    // Reset at EDGE_COUNT=5, BIT_COUNT=3 with P=8 on a low line
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.bitv = 1'b0;
      e.bcnt = k;
      e.ecnt = 6;
      exp_q.push_back(e);
    end
    bus.RX_IN = 1'b0;
    bus.COUNTER_EN = 1'b1;
    bus.SAMPLE_EN = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge CLK);
      #1;
      if (bus.EDGE_COUNT == 5'd5 && bus.BIT_COUNT == 4'd3) found = 1'b1;
    end
    check("reached_mid_frame", int'(found), 1);
    check("pre_reset_sampled_bit", int'(bus.SAMPLED_BIT), 0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("midrst_edge_count", int'(bus.EDGE_COUNT), 0);
    check("midrst_bit_count", int'(bus.BIT_COUNT), 0);
    check("midrst_sample_done", int'(bus.sample_done), 0);
    check("midrst_sampled_bit", int'(bus.SAMPLED_BIT), 1);
    @(negedge CLK);
    RST = 1'b0;
    bus.COUNTER_EN = 1'b0;
    bus.RX_IN = 1'b1;
    held = 1'b1;

    // COUNTER_EN low for 20 clocks with a noisy line
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      #1;
      check("disabled_edge_count", int'(bus.EDGE_COUNT), 0);
      check("disabled_bit_count", int'(bus.BIT_COUNT), 0);
      @(negedge CLK);
      bus.RX_IN = 1'($urandom);
    end

    // Counters run without sampling; SAMPLED_BIT must hold
    bus.SAMPLE_EN = 1'b0;
    bus.PRESCALE = 5'd6;
    bus.COUNTER_EN = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge CLK);
      #1;
      check("nosample_edge_count", int'(bus.EDGE_COUNT), i % 6);
      check("nosample_bit_count", int'(bus.BIT_COUNT), (i / 6) % 16);
      check("nosample_held_bit", int'(bus.SAMPLED_BIT), int'(held));
      @(negedge CLK);
      bus.RX_IN = 1'($urandom);
    end
    bus.COUNTER_EN = 1'b0;
    repeat (4) @(negedge CLK);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_edge_sampler.md
Name: uart_rx_edge_sampler

Overview:
- Oversampling timebase and majority-vote bit sampler for the UART receiver.
- Sits directly upstream of the RX control FSM. It produces EDGE_COUNT, BIT_COUNT and sample_done for the FSM, and SAMPLED_BIT for the deserializer and the start/parity/stop checkers.
- The FSM drives COUNTER_EN and SAMPLE_EN back into this block.

Parameters:
- SYNC_STAGES, 2, number of RX_IN synchronizer flops. 0 bypasses the synchronizer.
- PRESCALE_W, 5, width of PRESCALE and EDGE_COUNT.
- BIT_CNT_W, 4, width of BIT_COUNT.

Ports:
- CLK  in  1  single system clock. One clock; reset is synchronous and active-high.
- RST  in  1  synchronous active-high reset, sampled on the CLK rising edge.
- RX_IN  in  1  serial line, idle high.
- PRESCALE  in  PRESCALE_W  oversampling ratio, in clocks per bit.
- COUNTER_EN  in  1  run edge/bit counters. Low clears both counters.
- SAMPLE_EN  in  1  enable sample capture and majority vote.
- EDGE_COUNT  out  PRESCALE_W  oversampling edge index within the current bit.
- BIT_COUNT  out  BIT_CNT_W  index of the current frame bit (0 = start bit).
- SAMPLED_BIT  out  1  majority-voted value of the current bit.
- sample_done  out  1  one-cycle pulse; SAMPLED_BIT is valid and new.

Behaviour:
- Reset values:
  - EDGE_COUNT=0, BIT_COUNT=0, sample_done=0.
  - SAMPLED_BIT=1.
  - Synchronizer flops and vote sample registers = 1 (idle line).
- RST has priority over every other input.
- Effective prescale:
  - P = max(PRESCALE, 4). Values 0..3 are treated as 4.
  - Mid point M = P>>1 (floor for odd P).
- rx_s is RX_IN delayed by SYNC_STAGES clocks. All sampling uses rx_s only.
- Edge counter:
  - COUNTER_EN=0: EDGE_COUNT<=0 and BIT_COUNT<=0 on the next edge.
  - COUNTER_EN=1 and EDGE_COUNT >= P-1: EDGE_COUNT<=0 and BIT_COUNT<=BIT_COUNT+1. BIT_COUNT wraps modulo 2^BIT_CNT_W, 15->0.
  - COUNTER_EN=1 otherwise: EDGE_COUNT<=EDGE_COUNT+1.
  - The >= compare means a PRESCALE decrease mid-bit wraps on the next cycle, with no runaway past P.
  - A PRESCALE increase takes effect immediately.
- Sampler, with SAMPLE_EN=1 and COUNTER_EN=1:
  - EDGE_COUNT==M-1: s0<=rx_s.
  - EDGE_COUNT==M: s1<=rx_s.
  - EDGE_COUNT==M+1: SAMPLED_BIT<=majority(s0,s1,rx_s) and sample_done<=1.
  - sample_done is therefore high in the cycle where EDGE_COUNT==M+2, for exactly one cycle.
  - sample_done fires exactly once per bit period.
- Sampler gating:
  - SAMPLE_EN=0: no capture and no pulse. SAMPLED_BIT holds its value.
  - Dropping SAMPLE_EN between the M-1 and M+1 captures suppresses that bit's pulse.
- Latency: RX_IN to vote input is SYNC_STAGES clocks. Vote to SAMPLED_BIT/sample_done is 1 clock.
- Simultaneous events:
  - COUNTER_EN falling in the M+1 cycle still completes the vote, since the registered result is taken from that cycle.
  - The counters clear on the same edge.
- Reset mid-frame: all state returns to reset values on the next edge, and no pulse is emitted. No other state is held.

Decomposition:
- Shared package uart_rx_pkg:
  - PRESCALE_MIN=4.
  - Widths PRESCALE_W and BIT_CNT_W.
  - Frame-length constants: 1 start bit, 8 data bits, optional parity bit, 1 stop bit.
  - Majority function maj3.
- One natural sub-module, uart_rx_sync: a SYNC_STAGES-deep bit synchronizer with reset value 1.
- Counters and the voter stay in the top module.

Test Plan:
- P=8, RX_IN low for 8 clocks from edge 0, COUNTER_EN=SAMPLE_EN=1.
  - sample_done pulses once, at EDGE_COUNT=6.
  - SAMPLED_BIT=0 and BIT_COUNT=0.
  - BIT_COUNT becomes 1 after EDGE_COUNT 7->0.
- P=16, bit value 1 with a one-clock low glitch on the M sample.
  - SAMPLED_BIT=1, since majority 1,0,1 gives 1.
  - Two-sample low glitch gives SAMPLED_BIT=0.
- P=16, full 11-bit frame 0_10100101_1_1 (data sent LSB-first, bits 1..8 are 0xA5 = 10100101).
  - Exactly 11 sample_done pulses.
  - SAMPLED_BIT sequence matches the frame.
  - BIT_COUNT reaches 10 and EDGE_COUNT never exceeds 15.
- PRESCALE=2 and PRESCALE=3:
  - Behaves as P=4, with EDGE_COUNT cycling 0..3 and the pulse at EDGE_COUNT=0 of the next bit (M=2, M+2=4 wraps).
  - Change PRESCALE 16->8 while EDGE_COUNT=12: wrap to 0 on the next clock and BIT_COUNT+1.
- Reset mid-bit with RST=1 at EDGE_COUNT=5, BIT_COUNT=3.
  - Next clock: all outputs at reset values (SAMPLED_BIT=1).
  - No sample_done.
- COUNTER_EN held low for 20 clocks:
  - EDGE_COUNT and BIT_COUNT stay 0 and no pulses.
  - With SAMPLE_EN=0 and COUNTER_EN=1, counters run, there are no pulses and SAMPLED_BIT holds.
